// File: rtl/pll_hdmi_pkg.sv
// Shared definitions for the HDMI PLL reconfiguration sequencer:
// management register map, sequencer state codes and C-counter word layout.
package pll_hdmi_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MODE      = 3'd1;
    localparam logic [2:0] ST_WR_N      = 3'd2;
    localparam logic [2:0] ST_WR_M      = 3'd3;
    localparam logic [2:0] ST_WR_K      = 3'd4;
    localparam logic [2:0] ST_WR_C      = 3'd5;
    localparam logic [2:0] ST_START     = 3'd6;
    localparam logic [2:0] ST_LOCK_WAIT = 3'd7;

    localparam int C_VAL_W   = 18;
    localparam int C_SEL_LSB = 18;
    localparam int C_SEL_W   = 5;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } mgmt_wr_t;

    // C-counter write word: output select above the 18-bit counter value
    function automatic logic [31:0] c_word(input logic [C_SEL_W-1:0] sel,
                                           input logic [C_VAL_W-1:0] val);
        c_word = {{(32 - C_SEL_LSB - C_SEL_W){1'b0}}, sel, val};
    endfunction

endpackage

// File: rtl/pll_hdmi_reconfig_lock.sv
// Lock qualifier: synchronises pll_locked and runs the stability and
// timeout counters while the sequencer waits for lock.
module pll_lock_qual
    import pll_hdmi_pkg::*;
#(
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic refclk,
    input  logic rst,
    input  logic en,
    input  logic pll_locked,
    output logic lk_s,
    output logic qualified,
    output logic timeout
);

    localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int TMO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = {STAB_W{1'b1}};
    localparam logic [TMO_W-1:0]  TMO_MAX   = {TMO_W{1'b1}};

    logic [1:0]        sync_r;
    logic [STAB_W-1:0] stab_r;
    logic [TMO_W-1:0]  tmo_r;

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pll_locked};
        end
    end

    assign lk_s = sync_r[1];

    // Saturating stability and timeout counters, held at zero outside the wait
    always_ff @(posedge refclk) begin
        if (rst || !en) begin
            stab_r <= {STAB_W{1'b0}};
            tmo_r  <= {TMO_W{1'b0}};
        end else begin
            if (!lk_s) begin
                stab_r <= {STAB_W{1'b0}};
            end else if (stab_r != STAB_MAX) begin
                stab_r <= stab_r + STAB_W'(1);
            end else begin
                stab_r <= stab_r;
            end
            if (tmo_r != TMO_MAX) begin
                tmo_r <= tmo_r + TMO_W'(1);
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end

    assign qualified = en & lk_s & (stab_r == STAB_LAST);
    assign timeout   = en & (tmo_r == TMO_LAST);

endmodule

// File: rtl/pll_hdmi_reconfig.sv
// HDMI pixel-clock PLL reconfiguration sequencer: latches a counter set,
// writes it over the Avalon-MM management port, starts reconfig, qualifies lock.
module pll_hdmi_reconfig
    import pll_hdmi_pkg::*;
#(
    parameter int NUM_CLKS     = 1,
    parameter int FRACTIONAL   = 1,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic                     refclk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [17:0]              cfg_n,
    input  logic [17:0]              cfg_m,
    input  logic [31:0]              cfg_k,
    input  logic [18*NUM_CLKS-1:0]   cfg_c,
    output logic [5:0]               mgmt_address,
    output logic                     mgmt_write,
    output logic [31:0]              mgmt_writedata,
    input  logic                     mgmt_waitrequest,
    input  logic                     pll_locked,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     locked,
    output logic                     lock_lost
);

    logic [2:0]             state_r, state_s;
    logic [4:0]             idx_r, idx_s;
    mgmt_wr_t               cmd_r, cmd_s;
    logic                   wr_r, wr_s;
    logic                   ready_r, ready_s;
    logic                   busy_r, busy_s, done_r, done_s;
    logic                   error_r, error_s, locked_r, locked_s, lost_r, lost_s;
    logic                   accept_s, hs_s;
    logic [17:0]            n_r, m_r;
    logic [31:0]            k_r;
    logic [18*NUM_CLKS-1:0] c_r;
    logic                   lk_s, qualified_s, timeout_s;

    pll_lock_qual #(
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_lock_qual (
        .refclk    (refclk),
        .rst       (rst),
        .en        (state_r == ST_LOCK_WAIT),
        .pll_locked(pll_locked),
        .lk_s      (lk_s),
        .qualified (qualified_s),
        .timeout   (timeout_s)
    );

    // Next-state decode; each write state holds its command until waitrequest drops
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        cmd_s    = cmd_r;
        wr_s     = wr_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        error_s  = error_r;
        locked_s = locked_r;
        lost_s   = lost_r;
        accept_s = 1'b0;
        hs_s     = wr_r & ~mgmt_waitrequest;
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid && ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_MODE;
                    wr_s     = 1'b1;
                    cmd_s    = '{addr: ADDR_MODE, data: 32'd0};
                    busy_s   = 1'b1;
                    error_s  = 1'b0;
                    locked_s = 1'b0;
                    lost_s   = 1'b0;
                end else if (!lk_s && locked_r) begin
                    locked_s = 1'b0;
                    lost_s   = 1'b1;
                end else begin
                    wr_s = 1'b0;
                end
            end
            ST_MODE: begin
                if (hs_s) begin
                    state_s = ST_WR_N;
                    cmd_s   = '{addr: ADDR_N, data: {14'd0, n_r}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_WR_N: begin
                if (hs_s) begin
                    state_s = ST_WR_M;
                    cmd_s   = '{addr: ADDR_M, data: {14'd0, m_r}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_WR_M: begin
                if (hs_s && (FRACTIONAL != 0)) begin
                    state_s = ST_WR_K;
                    cmd_s   = '{addr: ADDR_K, data: k_r};
                end else if (hs_s) begin
                    state_s = ST_WR_C;
                    cmd_s   = '{addr: ADDR_C, data: c_word(5'd0, c_r[C_VAL_W-1:0])};
                end else begin
                    state_s = state_r;
                end
            end
            ST_WR_K: begin
                if (hs_s) begin
                    state_s = ST_WR_C;
                    cmd_s   = '{addr: ADDR_C, data: c_word(5'd0, c_r[C_VAL_W-1:0])};
                end else begin
                    state_s = state_r;
                end
            end
            ST_WR_C: begin
                if (hs_s && (idx_r == 5'(NUM_CLKS - 1))) begin
                    state_s = ST_START;
                    idx_s   = 5'd0;
                    cmd_s   = '{addr: ADDR_START, data: 32'd1};
                end else if (hs_s) begin
                    idx_s = idx_r + 5'd1;
                    cmd_s = '{addr: ADDR_C,
                              data: c_word(idx_s, c_r[C_VAL_W*int'(idx_s) +: C_VAL_W])};
                end else begin
                    state_s = state_r;
                end
            end
            ST_START: begin
                if (hs_s) begin
                    state_s = ST_LOCK_WAIT;
                    wr_s    = 1'b0;
                    cmd_s   = '{addr: 6'd0, data: 32'd0};
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOCK_WAIT: begin
                if (qualified_s) begin
                    state_s  = ST_IDLE;
                    locked_s = 1'b1;
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                end else if (timeout_s) begin
                    state_s  = ST_IDLE;
                    error_s  = 1'b1;
                    locked_s = 1'b0;
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                wr_s    = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
    end

    // Sequencer state, Avalon master outputs, status flags and latched counter set
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= 5'd0;
            cmd_r    <= '{addr: 6'd0, data: 32'd0};
            wr_r     <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            locked_r <= 1'b0;
            lost_r   <= 1'b0;
            n_r      <= 18'd0;
            m_r      <= 18'd0;
            k_r      <= 32'd0;
            c_r      <= {(18*NUM_CLKS){1'b0}};
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            cmd_r    <= cmd_s;
            wr_r     <= wr_s;
            ready_r  <= ready_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            error_r  <= error_s;
            locked_r <= locked_s;
            lost_r   <= lost_s;
            if (accept_s) begin
                n_r <= cfg_n;
                m_r <= cfg_m;
                k_r <= cfg_k;
                c_r <= cfg_c;
            end
        end
    end

    assign cfg_ready      = ready_r;
    assign mgmt_address   = cmd_r.addr;
    assign mgmt_writedata = cmd_r.data;
    assign mgmt_write     = wr_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign locked         = locked_r;
    assign lock_lost      = lost_r;

endmodule
